// File: rtl/vip_pkg.sv
// Shared constants for the 1-bit morphology stage of the video chain.
//   MORPH_*            run-time operator encodings carried on mode_sel
//   VIP_MORPH_LAT      input-to-output latency in clocks (syncs and pixel)
//   VIP_MORPH_STATS_W  width of the per-frame ones counter
//   morph_apply()      3x3 operator on a packed window {right, centre, left} columns,
//                      each column {top, mid, bottom}
package vip_pkg;

  localparam logic [1:0] MORPH_BYPASS = 2'd0;
  localparam logic [1:0] MORPH_ERODE  = 2'd1;
  localparam logic [1:0] MORPH_DILATE = 2'd2;

  localparam int unsigned VIP_MORPH_LAT     = 3;
  localparam int unsigned VIP_MORPH_STATS_W = 22;

  // Bit 4 is the centre tap (middle row of the middle column).
  // The unused encoding 3 falls through to bypass.
  function automatic logic morph_apply(input logic [1:0] mode, input logic [8:0] taps);
    logic res;
    case (mode)
      MORPH_ERODE:  res = &taps;
      MORPH_DILATE: res = |taps;
      default:      res = taps[4];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/vip_bit_line_buffer.sv
// Two cascaded Depth x 1 bit line delays addressed by column.
//   clk   pixel clock
//   we    write strobe (one accepted in-range pixel)
//   addr  column of the current pixel
//   din   current pixel bit
//   tap1  same column, previous line (value before this cycle's write)
//   tap2  same column, two lines back (value before this cycle's write)
// Contents are deliberately not reset; rows that could see stale data are masked
// downstream.
module vip_bit_line_buffer #(
  parameter int unsigned Depth = 640,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic             din,
  output logic             tap1,
  output logic             tap2
);

  logic [Depth-1:0] line1_q;
  logic [Depth-1:0] line2_q;

  assign tap1 = line1_q[addr];
  assign tap2 = line2_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      line1_q[addr] <= din;
      line2_q[addr] <= line1_q[addr];
    end
  end

endmodule

// File: rtl/vip_bit_morph_filter.sv
// 3x3 binary erosion / dilation / pass-through on a 1-bit edge map.
//   clk, rst               pixel clock, synchronous active-high reset
//   per_frame_vsync/href/clken, per_img_Bit   input video stream
//   mode_sel               0 bypass, 1 erode, 2 dilate, 3 bypass; latched per frame
//   post_frame_vsync/href/clken               input syncs delayed by three clocks
//   post_img_Bit           processed pixel, window centred one pixel and one line back
//   post_ones_cnt          ones in the last output frame (VIP_MORPH_STATS_EN)
//   post_stats_valid       one-clock pulse when post_ones_cnt updates (VIP_MORPH_STATS_EN)
// Build option: define VIP_MORPH_STATS_EN to build the ones counter; otherwise the two
// stats outputs are tied to zero.
module vip_bit_morph_filter
  import vip_pkg::*;
#(
  parameter logic [11:0] IMG_HDISP = 12'd640,
  parameter logic [11:0] IMG_VDISP = 12'd480
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         per_frame_vsync,
  input  logic                         per_frame_href,
  input  logic                         per_frame_clken,
  input  logic                         per_img_Bit,
  input  logic [1:0]                   mode_sel,
  output logic                         post_frame_vsync,
  output logic                         post_frame_href,
  output logic                         post_frame_clken,
  output logic                         post_img_Bit,
  output logic [VIP_MORPH_STATS_W-1:0] post_ones_cnt,
  output logic                         post_stats_valid
);

  localparam int unsigned AddrW = $clog2(int'(IMG_HDISP));

  logic        vsync_q, href_q;
  logic [11:0] col_q, row_q;
  logic        col_full_q, row_full_q;
  logic        frame_ok_q;
  logic [1:0]  mode_q;
  logic [2:0]  win0_q, win1_q, win2_q;  // oldest .. newest column, {top, mid, bottom}
  logic        vld1_q, vld2_q, res2_q;
  logic [2:0]  sync_q [VIP_MORPH_LAT];  // {vsync, href, clken} per stage

  logic vsync_rise, href_fall, pix, in_range, tap1, tap2;

  assign vsync_rise = per_frame_vsync & ~vsync_q;
  assign href_fall  = href_q & ~per_frame_href;
  assign pix        = per_frame_clken & per_frame_href;
  // The full flags mark pixels/lines past the active area once the counters saturate.
  assign in_range   = ~col_full_q & ~row_full_q;

  vip_bit_line_buffer #(
    .Depth (int'(IMG_HDISP)),
    .AddrW (AddrW)
  ) u_line_buffer (
    .clk  (clk),
    .we   (pix & in_range),
    .addr (col_q[AddrW-1:0]),
    .din  (per_img_Bit),
    .tap1 (tap1),
    .tap2 (tap2)
  );

  // Frame / line position tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset high so a reset released mid-frame does not see a false frame start.
      vsync_q    <= 1'b1;
      href_q     <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      col_full_q <= 1'b0;
      row_full_q <= 1'b0;
      frame_ok_q <= 1'b0;
      mode_q     <= MORPH_BYPASS;
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
      if (vsync_rise) begin
        mode_q     <= mode_sel;
        frame_ok_q <= 1'b1;
      end
      if (vsync_rise || href_fall) begin
        col_q      <= '0;
        col_full_q <= 1'b0;
      end else if (pix) begin
        if (col_q == IMG_HDISP - 12'd1) col_full_q <= 1'b1;
        else                            col_q      <= col_q + 12'd1;
      end
      if (vsync_rise) begin
        row_q      <= '0;
        row_full_q <= 1'b0;
      end else if (href_fall) begin
        if (row_q == IMG_VDISP - 12'd1) row_full_q <= 1'b1;
        else                            row_q      <= row_q + 12'd1;
      end
    end
  end

  // Three-stage pixel pipeline: window shift, operator, mask
  always_ff @(posedge clk) begin
    if (rst) begin
      win0_q       <= '0;
      win1_q       <= '0;
      win2_q       <= '0;
      vld1_q       <= 1'b0;
      vld2_q       <= 1'b0;
      res2_q       <= 1'b0;
      post_img_Bit <= 1'b0;
      for (int i = 0; i < VIP_MORPH_LAT; i++) sync_q[i] <= '0;
    end else begin
      if (pix) begin
        win0_q <= win1_q;
        win1_q <= win2_q;
        win2_q <= {tap2, tap1, per_img_Bit};
      end
      // The centre lags the input by one column and one row, so the first two
      // input columns/rows never give a complete window.
      vld1_q <= pix & in_range & frame_ok_q & (col_q >= 12'd2) & (row_q >= 12'd2);
      vld2_q <= vld1_q;
      res2_q <= morph_apply(mode_q, {win2_q, win1_q, win0_q});
      if (sync_q[VIP_MORPH_LAT-2][0]) post_img_Bit <= vld2_q & res2_q;
      sync_q[0] <= {per_frame_vsync, per_frame_href, per_frame_clken};
      for (int i = 1; i < VIP_MORPH_LAT; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign post_frame_vsync = sync_q[VIP_MORPH_LAT-1][2];
  assign post_frame_href  = sync_q[VIP_MORPH_LAT-1][1];
  assign post_frame_clken = sync_q[VIP_MORPH_LAT-1][0];

`ifdef VIP_MORPH_STATS_EN
  logic [VIP_MORPH_STATS_W-1:0] cnt_q, cnt_d;
  logic                         vsync_fall;

  // Output vsync is about to drop: the stage-2 copy is already low.
  assign vsync_fall = post_frame_vsync & ~sync_q[VIP_MORPH_LAT-2][2];

  always_comb begin
    cnt_d = cnt_q;
    if (post_frame_vsync && post_frame_clken && post_img_Bit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q            <= '0;
      post_ones_cnt    <= '0;
      post_stats_valid <= 1'b0;
    end else begin
      post_stats_valid <= vsync_fall;
      if (vsync_fall) begin
        post_ones_cnt <= cnt_d;
        cnt_q         <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end
`else
  assign post_ones_cnt    = '0;
  assign post_stats_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vip_bit_morph_filter.sv
// Directed + randomized bench for vip_bit_morph_filter on an 8x6 image. A frame-level
// reference model keeps the current frame as a 2-D bit array and evaluates every
// accepted pixel directly from the 3x3 neighbourhood rules.
module tb_vip_bit_morph_filter;

  localparam logic [11:0] H = 12'd8;
  localparam logic [11:0] V = 12'd6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vs, hr, ce, bit_in;
  logic [1:0]  mode;
  logic        post_vs, post_hr, post_ce, post_bit, post_valid;
  logic [21:0] post_cnt;

  vip_bit_morph_filter #(
    .IMG_HDISP (H),
    .IMG_VDISP (V)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .per_frame_vsync  (vs),
    .per_frame_href   (hr),
    .per_frame_clken  (ce),
    .per_img_Bit      (bit_in),
    .mode_sel         (mode),
    .post_frame_vsync (post_vs),
    .post_frame_href  (post_hr),
    .post_frame_clken (post_ce),
    .post_img_Bit     (post_bit),
    .post_ones_cnt    (post_cnt),
    .post_stats_valid (post_valid)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  bit          img [16][16];
  int          mc, mr;
  logic        m_ok, last_v, last_h;
  logic [1:0]  m_mode;
  logic [2:0]  hs [3];  // expected {vsync, href, clken} for the last three steps
  logic        hres [3];
  logic        exp_bit, prev_v;
  int          acc, frame_ones;
  logic [21:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_pix(input int c, input int r);
    int ones;
    ones = 0;
    if (!m_ok || c >= int'(H) || r >= int'(V) || c < 2 || r < 2) return 1'b0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) ones += int'(img[r-dr][c-dc]);
    case (m_mode)
      2'd1:    return ones == 9;
      2'd2:    return ones != 0;
      default: return img[r-1][c-1];
    endcase
  endfunction

  // One clock: apply inputs, advance the model, sample outputs 1 ns after the edge.
  task automatic step(input logic v, input logic h, input logic c_en, input logic b);
    logic res;
    logic exp_valid;
    res = 1'b0;
    if (v && !last_v) begin
      m_ok = 1'b1; m_mode = mode; mr = 0; mc = 0;
    end
    if (last_h && !h) begin
      mr++; mc = 0;
    end
    last_v = v;
    last_h = h;
    if (c_en && h) begin
      if (mc < int'(H) && mr < int'(V)) img[mr][mc] = b;
      res = ref_pix(mc, mr);
      mc++;
    end
    vs = v; hr = h; ce = c_en; bit_in = b;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        hs[i] = '0; hres[i] = 1'b0;
      end
      exp_bit = 1'b0; prev_v = 1'b0; acc = 0; exp_cnt = '0; m_ok = 1'b0; last_h = 1'b0;
    end else begin
      hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = {v, h, c_en};
      hres[2] = hres[1]; hres[1] = hres[0]; hres[0] = res;
    end
    if (hs[2][0]) exp_bit = hres[2];
    chk("post_vsync", 32'(post_vs), 32'(hs[2][2]));
    chk("post_href", 32'(post_hr), 32'(hs[2][1]));
    chk("post_clken", 32'(post_ce), 32'(hs[2][0]));
    chk("post_bit", 32'(post_bit), 32'(exp_bit));
`ifdef VIP_MORPH_STATS_EN
    exp_valid = prev_v && !hs[2][2];
    if (exp_valid) begin
      exp_cnt = 22'(acc);
      acc = 0;
    end
    if (hs[2][2] && hs[2][0] && exp_bit) acc++;
`else
    exp_valid = 1'b0;
`endif
    chk("stats_valid", 32'(post_valid), 32'(exp_valid));
    chk("ones_cnt", 32'(post_cnt), 32'(exp_cnt));
    prev_v = hs[2][2];
    if (post_vs && post_ce && post_bit) frame_ones++;
  endtask

  function automatic logic pix_val(input int kind, input int c, input int r);
    case (kind)
      0:       return 1'b1;
      1:       return (c == 4) && (r == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // kind: 0 all ones, 1 single one at (4,3), 2 random. gap: random idle clocks
  // (~50% clken density). switch_line: line at which mode_sel becomes md2.
  // rst_line: line where a 2-clock reset is inserted. exp_ones < 0 skips the total check.
  task automatic frame(input logic [1:0] md, input int kind, input int extra_c,
                       input int extra_r, input bit gap, input int switch_line,
                       input logic [1:0] md2, input int rst_line, input int exp_ones);
    frame_ones = 0;
    mode = md;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < int'(V) + extra_r; r++) begin
      if (r == switch_line) mode = md2;
      for (int c = 0; c < int'(H) + extra_c; c++) begin
        if (r == rst_line && c == 3) begin
          rst = 1'b1;
          step(1'b1, 1'b1, 1'b0, 1'b0);
          step(1'b1, 1'b1, 1'b0, 1'b0);
          rst = 1'b0;
        end
        if (gap) repeat ($urandom_range(0, 2)) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, pix_val(kind, c, r));
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
    if (exp_ones >= 0) chk("frame_ones", 32'(frame_ones), 32'(exp_ones));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; vs = 1'b0; hr = 1'b0; ce = 1'b0; bit_in = 1'b0; mode = 2'd0;
    mc = 0; mr = 0; m_ok = 1'b0; last_v = 1'b0; last_h = 1'b0; m_mode = 2'd0;
    exp_bit = 1'b0; prev_v = 1'b0; acc = 0; exp_cnt = '0; frame_ones = 0;
    for (int i = 0; i < 3; i++) begin
      hs[i] = '0; hres[i] = 1'b0;
    end
    // Reset state
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Erode on all ones: centres col 1..6, row 1..4
    frame(2'd1, 0, 0, 0, 1'b0, -1, 2'd0, -1, 24);
    // Dilate a single one: 3x3 block
    frame(2'd2, 1, 0, 0, 1'b0, -1, 2'd0, -1, 9);
    // Mode changed mid-frame stays erode; the next frame picks up dilate
    frame(2'd1, 2, 0, 0, 1'b0, 2, 2'd2, -1, -1);
    frame(2'd2, 2, 0, 0, 1'b0, -1, 2'd2, -1, -1);
    // Encoding 3 acts as bypass
    frame(2'd3, 2, 0, 0, 1'b1, -1, 2'd3, -1, -1);
    frame(2'd3, 0, 0, 0, 1'b0, -1, 2'd3, -1, 24);
    // Reset mid-frame, then a clean frame
    frame(2'd2, 2, 0, 0, 1'b1, -1, 2'd2, 3, -1);
    frame(2'd2, 2, 0, 0, 1'b1, -1, 2'd2, -1, -1);
    // Over-long lines and an extra line are masked and not written
    frame(2'd1, 0, 10, 1, 1'b0, -1, 2'd1, -1, 24);
    frame(2'd2, 2, 10, 1, 1'b1, -1, 2'd2, -1, -1);
    frame(2'd0, 2, 10, 0, 1'b1, -1, 2'd0, -1, -1);
    // Random frames with clken gaps and random operators
    for (int f = 0; f < 6; f++) begin
      frame(2'($urandom_range(0, 3)), 2, 0, 0, 1'b1, -1, 2'd0, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/vip_bit_morph_filter.md
# vip_bit_morph_filter

Parametrised 3x3 binary morphology stage for the video image processing chain; it consumes the 1-bit edge map produced by the Sobel detector. It performs erosion, dilation or pass-through, selected at run time and locked per frame. It holds its own two-line bit buffer and a 3x3 window. Output syncs are the input syncs delayed by a fixed three clocks.

## Interface
- IMG_HDISP, 12'd640, active pixels per line (2..2048)
- IMG_VDISP, 12'd480, active lines per frame (2..2048)
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- per_frame_vsync  in  1  input frame sync, high during the frame
- per_frame_href  in  1  input line valid
- per_frame_clken  in  1  input pixel strobe
- per_img_Bit  in  1  input binary pixel
- mode_sel  in  2  0 bypass, 1 erode, 2 dilate, 3 treated as bypass
- post_frame_vsync  out  1  per_frame_vsync delayed 3 clk
- post_frame_href  out  1  per_frame_href delayed 3 clk
- post_frame_clken  out  1  per_frame_clken delayed 3 clk
- post_img_Bit  out  1  processed pixel
- post_ones_cnt  out  22  count of 1-pixels in the last output frame (stats option)
- post_stats_valid  out  1  1-clk pulse when post_ones_cnt updates (stats option)

## Operation
- Reset: all outputs are 0, counters are 0, mode_q is bypass, and frame_ok is 0.
- mode_q samples mode_sel on the rising edge of per_frame_vsync (the edge cycle's value). It is constant for the rest of the frame. frame_ok is set at the same edge.
- col counts clken pulses while href is high and clears on the href falling edge. row increments on each href falling edge and clears on the vsync rising edge. Both saturate at DISP-1.
- Each clken with href high and col < IMG_HDISP writes per_img_Bit into the line buffer. The taps are the current pixel, the same column one line earlier, and two lines earlier.
- The 3x3 window shifts left on each clken. For input at (c,r), the window is centred on (c-1,r-1). Output is therefore shifted by one pixel and one line; the last column and last row are never centre pixels.
- Result:
  - erode = AND of 9 taps
  - dilate = OR of 9 taps
  - bypass = centre tap
- Border mask: the result is forced to 0 when c<2, r<2, frame_ok=0, or the pixel is beyond saturation (href longer than IMG_HDISP, or more lines than IMG_VDISP). Those extra pixels are also not written.
- Line buffer contents are not cleared between frames. The row<2 mask hides stale data.
- Reset mid-frame clears everything. Output stays 0 (masked) until the next vsync rising edge.

## Timing
- Stage 1: tap read and window shift.
- Stage 2: AND/OR/centre select.
- Stage 3: mask and output register.
- Syncs pass through the same 3-register delay.
- post_img_Bit updates only in cycles where post_frame_clken is 1 and holds otherwise.
- clken gaps of any length are legal. The window advances only on clken.
- The output-side falling edge of post_frame_vsync coincides with the post_stats_valid pulse.

## Configuration
- `VIP_MORPH_STATS_EN` defined:
  - A 22-bit counter increments on each post_frame_clken with post_img_Bit=1 while post_frame_vsync is high.
  - On the post_frame_vsync falling edge, the count is copied to post_ones_cnt, the counter clears, and post_stats_valid pulses for 1 clk.
  - The counter saturates at 2^22-1.
- Undefined: post_ones_cnt and post_stats_valid are tied to 0, and no counter logic is built.

## Structure
- vip_pkg holds:
  - the mode constants MORPH_BYPASS=2'd0, MORPH_ERODE=2'd1, MORPH_DILATE=2'd2
  - the pipeline latency constant VIP_MORPH_LAT=3
  - the stats width constant 22
- Sub-module vip_bit_line_buffer: two cascaded IMG_HDISP x 1 bit delay lines addressed by col, with write on clken and a read-before-write tap output.

## Test plan
- IMG 8x6, erode, all-ones frame: post_img_Bit=1 exactly for centre col 1..6 and centre row 1..4; all other pixels 0; stats post_ones_cnt=24.
- Dilate, single 1 at (4,3): a 3x3 block of ones centred on (4,3) in output coordinates; stats count=9.
- mode_sel changed from 1 to 2 mid-frame: the current frame stays erode; the next frame is dilate; mode_sel=3 gives bypass.
- Rst asserted for 2 clk mid-frame: all outputs 0 next clk; output stays 0 until the next vsync rising edge; the following frame matches the golden model.
- Random clken gaps (50% density), 640x480 random bits: bit-exact against the software model, with post syncs equal to input syncs delayed 3 clk.
- href 10 pixels longer than IMG_HDISP=8: extra pixels are output as 0, and line buffer contents for the next line are unaffected.
